// File: rtl/cpu_pkg.sv
// Shared word width, default address width and memory-responder FSM encoding.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cpu_pkg;

    localparam int unsigned WORD_WIDTH    = 32;
    localparam int unsigned ADDR_BITS_DEF = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

endpackage

// File: rtl/ram_array.sv
// Single-port word RAM with synchronous write and registered synchronous read.
// Latency: read data appears one edge after the address; writes land at the edge.
// Backpressure: none; the port accepts one operation every cycle.
module ram_array
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_BITS = ADDR_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] rdata
);

    logic [WORD_WIDTH-1:0] mem_q [2**ADDR_BITS];
    logic [WORD_WIDTH-1:0] rdata_q;

    // Contents are deliberately left without reset; a read is issued whenever no write is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end else begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/memory_responder.sv
// Edge-armed memory responder: one read or write per strobe rise, WAIT_STATES extra cycles.
// Latency: access performed WAIT_STATES+1 edges after the accepting edge; Done follows for one cycle.
// Backpressure: strobes arriving while Busy are dropped, not queued; Read+Write together pulses Error.
module memory_responder
    import cpu_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned ADDR_BITS   = ADDR_BITS_DEF
) (
    input  logic                  Clock,
    input  logic                  clear,
    input  logic                  Read,
    input  logic                  Write,
    input  logic [WORD_WIDTH-1:0] mar_data,
    input  logic [WORD_WIDTH-1:0] mdr_data,
    output logic [WORD_WIDTH-1:0] Mdatain,
    output logic                  Done,
    output logic                  Busy,
    output logic                  Error
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    mem_state_t            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  rd_prev_q, rd_prev_d;
    logic                  wr_prev_q, wr_prev_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
    logic                  op_wr_q, op_wr_d;
    logic [WORD_WIDTH-1:0] mdat_q, mdat_d;
    logic                  err_q, err_d;

    logic                  rd_rise, wr_rise;
    logic                  ram_we;
    logic [ADDR_BITS-1:0]  ram_addr;
    logic [WORD_WIDTH-1:0] ram_rdata;
    logic                  unused_mar_hi;

    // Upper address bits are ignored, so addresses wrap modulo the memory depth.
    assign unused_mar_hi = ^mar_data[WORD_WIDTH-1:ADDR_BITS];

    assign rd_rise = Read  & ~rd_prev_q;
    assign wr_rise = Write & ~wr_prev_q;

    // Next-state, request capture and access sequencing.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_prev_d = Read;
        wr_prev_d = Write;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        op_wr_d   = op_wr_q;
        mdat_d    = mdat_q;
        err_d     = 1'b0;
        ram_we    = 1'b0;
        // In IDLE the RAM already reads the incoming address, so a zero-wait read
        // has its word ready at the perform edge.
        ram_addr  = (state_q == IDLE) ? mar_data[ADDR_BITS-1:0] : addr_q;

        unique case (state_q)
            IDLE: begin
                if (rd_rise && wr_rise) begin
                    err_d = 1'b1;
                end else if ((rd_rise && !Write) || (wr_rise && !Read)) begin
                    addr_d  = mar_data[ADDR_BITS-1:0];
                    wdata_d = mdr_data;
                    op_wr_d = wr_rise;
                    cnt_d   = WAIT_INIT;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ram_we  = op_wr_q;
                    if (!op_wr_q) begin
                        mdat_d = ram_rdata;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; history flops reset high so a held strobe is not taken.
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            rd_prev_q <= 1'b1;
            wr_prev_q <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            op_wr_q   <= 1'b0;
            mdat_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_prev_q <= rd_prev_d;
            wr_prev_q <= wr_prev_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            op_wr_q   <= op_wr_d;
            mdat_q    <= mdat_d;
            err_q     <= err_d;
        end
    end

    ram_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk   (Clock),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign Mdatain = mdat_q;
    assign Done    = (state_q == DONE);
    assign Busy    = (state_q != IDLE);
    assign Error   = err_q;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: three instances (0, 1 and 3 wait states) share one stimulus stream.
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: per-instance memory and read-data model tracks expected behaviour.
module tb_memory_responder;

    logic        Clock = 1'b0;
    logic        clear;
    logic        Read;
    logic        Write;
    logic [31:0] mar_data;
    logic [31:0] mdr_data;

    logic [31:0] mdat_a [3];
    logic [2:0]  done_v;
    logic [2:0]  busy_v;
    logic [2:0]  err_v;

    int unsigned wst [3] = '{0, 1, 3};

    // Reference state: each instance has its own memory image and last read word.
    logic [31:0] mm       [3][512];
    logic [31:0] mdl_mdat [3];
    int          written  [$];

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    memory_responder #(.WAIT_STATES(0), .ADDR_BITS(9)) u_w0 (
        .Clock(Clock), .clear(clear), .Read(Read), .Write(Write),
        .mar_data(mar_data), .mdr_data(mdr_data),
        .Mdatain(mdat_a[0]), .Done(done_v[0]), .Busy(busy_v[0]), .Error(err_v[0])
    );
    memory_responder #(.WAIT_STATES(1), .ADDR_BITS(9)) u_w1 (
        .Clock(Clock), .clear(clear), .Read(Read), .Write(Write),
        .mar_data(mar_data), .mdr_data(mdr_data),
        .Mdatain(mdat_a[1]), .Done(done_v[1]), .Busy(busy_v[1]), .Error(err_v[1])
    );
    memory_responder #(.WAIT_STATES(3), .ADDR_BITS(9)) u_w3 (
        .Clock(Clock), .clear(clear), .Read(Read), .Write(Write),
        .mar_data(mar_data), .mdr_data(mdr_data),
        .Mdatain(mdat_a[2]), .Done(done_v[2]), .Busy(busy_v[2]), .Error(err_v[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All outputs of every instance against the model, with given control expectations per instance.
    task automatic chk_all(input string step, input logic [2:0] eb, input logic [2:0] ed, input logic [2:0] ee);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_busy_w%0d", step, wst[i]), {31'd0, busy_v[i]}, {31'd0, eb[i]});
            chk($sformatf("%s_done_w%0d", step, wst[i]), {31'd0, done_v[i]}, {31'd0, ed[i]});
            chk($sformatf("%s_err_w%0d",  step, wst[i]), {31'd0, err_v[i]},  {31'd0, ee[i]});
            chk($sformatf("%s_mdat_w%0d", step, wst[i]), mdat_a[i], mdl_mdat[i]);
        end
    endtask

    // One request: strobe(s) rise at the next edge k, stay high for 'hold' edges, then drop.
    // After edge k+j: busy while j <= W+1, Done only at j == W+1, which is also when the
    // access takes effect. A simultaneous Read/Write pulses Error right after edge k only.
    task automatic do_access(input string step, input bit rd, input bit wr,
                             input logic [31:0] addr, input logic [31:0] data, input int hold);
        int idx;
        int window;
        logic [2:0] eb, ed, ee;
        idx    = int'(addr[8:0]);
        window = (hold > 5) ? hold + 2 : 7;
        @(negedge Clock);
        Read     = rd;
        Write    = wr;
        mar_data = addr;
        mdr_data = data;
        for (int j = 0; j < window; j++) begin
            @(negedge Clock);
            eb = '0; ed = '0; ee = '0;
            for (int i = 0; i < 3; i++) begin
                if (rd && wr) begin
                    ee[i] = (j == 0);
                end else begin
                    eb[i] = (j <= int'(wst[i]) + 1);
                    ed[i] = (j == int'(wst[i]) + 1);
                    if (ed[i] && rd) mdl_mdat[i] = mm[i][idx];
                    if (ed[i] && wr) mm[i][idx] = data;
                end
            end
            chk_all($sformatf("%s_j%0d", step, j), eb, ed, ee);
            if (j == hold - 1) begin
                Read  = 1'b0;
                Write = 1'b0;
            end
        end
    endtask

    task automatic note_written(input logic [31:0] addr);
        written.push_back(int'(addr[8:0]));
    endtask

    initial begin
        int a;
        logic [31:0] ad, dt;

        clear    = 1'b0;
        Read     = 1'b0;
        Write    = 1'b0;
        mar_data = '0;
        mdr_data = '0;
        for (int i = 0; i < 3; i++) mdl_mdat[i] = '0;

        // Reset values.
        repeat (2) @(negedge Clock);
        chk_all("reset", 3'b000, 3'b000, 3'b000);
        clear = 1'b1;
        repeat (2) @(negedge Clock);
        chk_all("post_reset", 3'b000, 3'b000, 3'b000);

        // Preload 0x010 then read it back (zero-wait instance: Done and data at k+1).
        do_access("wr010", 1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 1);
        note_written(32'h10);
        do_access("rd010", 1'b1, 1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 1);

        // Write 0x054, then read through an aliased address 0x254.
        do_access("wr054", 1'b0, 1'b1, 32'h0000_0054, 32'h0000_ABCD, 2);
        note_written(32'h54);
        do_access("rd254", 1'b1, 1'b0, 32'h0000_0254, 32'h0, 1);

        // Held strobe gives exactly one access; dropping and re-raising gives another.
        do_access("hold10", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 10);
        do_access("rearm",  1'b1, 1'b0, 32'h0000_0054, 32'h0, 1);

        // Read and Write together: Error pulse, no access, memory untouched.
        do_access("both", 1'b1, 1'b1, 32'h0000_0054, 32'hDEAD_BEEF, 2);
        do_access("rd054_after_err", 1'b1, 1'b0, 32'h0000_0054, 32'h0, 1);

        // Reset two edges into a write of 0x020.
        do_access("wr020_old", 1'b0, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 1);
        note_written(32'h20);
        @(negedge Clock);
        Write    = 1'b1;
        mar_data = 32'h0000_0020;
        mdr_data = 32'h55AA_1234;
        repeat (2) @(negedge Clock);
        // Only the zero-wait instance has performed its write by edge k+1.
        mm[0][32'h20] = 32'h55AA_1234;
        clear = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) mdl_mdat[i] = '0;
        chk_all("clear_now", 3'b000, 3'b000, 3'b000);
        repeat (2) @(negedge Clock);
        clear = 1'b1;
        // Write still high at release must not start an access.
        repeat (3) begin
            @(negedge Clock);
            chk_all("held_at_release", 3'b000, 3'b000, 3'b000);
        end
        Write = 1'b0;
        @(negedge Clock);
        do_access("rd020", 1'b1, 1'b0, 32'h0000_0020, 32'h0, 1);

        // Randomized traffic with random upper address bits.
        for (int n = 0; n < 24; n++) begin
            if (($urandom_range(0, 1) == 0) || (written.size() == 0)) begin
                ad = {$urandom_range(0, 32'h7F_FFFF), 9'($urandom_range(0, 511))};
                dt = $urandom;
                do_access($sformatf("rnd%0d_wr", n), 1'b0, 1'b1, ad, dt, int'($urandom_range(1, 4)));
                note_written(ad);
            end else begin
                a  = written[$urandom_range(0, written.size() - 1)];
                ad = {$urandom_range(0, 32'h7F_FFFF), 9'(a)};
                do_access($sformatf("rnd%0d_rd", n), 1'b1, 1'b0, ad, 32'h0, int'($urandom_range(1, 4)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
